// File: rtl/cos_make_dds_if.sv
// Output bundle of the dual-tone DDS: 100 kHz tone and 1 MHz carrier samples.
interface cos_make_dds_if;
   logic signed [8:0] cos_100k;
   logic signed [7:0] cos_1M;

   modport master (output cos_100k, output cos_1M);
   modport slave  (input  cos_100k, input  cos_1M);
endinterface

// File: rtl/cos_make_dds.sv
// Free-running dual DDS: two 32-bit phase accumulators driving quarter-wave
// cosine ROMs (amplitudes 255 and 127) with registered two's-complement outputs.
module cos_make_dds #(
   parameter logic [31:0] FTW_100K = 32'd4294967,
   parameter logic [31:0] FTW_1M   = 32'd42949673
) (
   input  logic           clk,
   input  logic           rst_n,
   cos_make_dds_if.master dds_o
);

   logic [31:0]       ph_100k_q, ph_100k_d;
   logic [31:0]       ph_1M_q,   ph_1M_d;
   logic signed [8:0] cos_100k_q, cos_100k_d;
   logic signed [7:0] cos_1M_q,   cos_1M_d;
   logic [7:0]        mag_100k;
   logic [6:0]        mag_1M;

   // Quadrants 1 and 3 read the ROM mirrored about index 64.
   function automatic logic [6:0] fold_addr(input logic [7:0] p);
      return p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
   endfunction

   function automatic logic fold_neg(input logic [7:0] p);
      return p[7] ^ p[6];
   endfunction

   function automatic logic [7:0] rom_255(input logic [6:0] a);
      case (a)
         7'd0:  rom_255 = 8'd255;
         7'd1:  rom_255 = 8'd255;
         7'd2:  rom_255 = 8'd255;
         7'd3:  rom_255 = 8'd254;
         7'd4:  rom_255 = 8'd254;
         7'd5:  rom_255 = 8'd253;
         7'd6:  rom_255 = 8'd252;
         7'd7:  rom_255 = 8'd251;
         7'd8:  rom_255 = 8'd250;
         7'd9:  rom_255 = 8'd249;
         7'd10: rom_255 = 8'd247;
         7'd11: rom_255 = 8'd246;
         7'd12: rom_255 = 8'd244;
         7'd13: rom_255 = 8'd242;
         7'd14: rom_255 = 8'd240;
         7'd15: rom_255 = 8'd238;
         7'd16: rom_255 = 8'd236;
         7'd17: rom_255 = 8'd233;
         7'd18: rom_255 = 8'd231;
         7'd19: rom_255 = 8'd228;
         7'd20: rom_255 = 8'd225;
         7'd21: rom_255 = 8'd222;
         7'd22: rom_255 = 8'd219;
         7'd23: rom_255 = 8'd215;
         7'd24: rom_255 = 8'd212;
         7'd25: rom_255 = 8'd208;
         7'd26: rom_255 = 8'd205;
         7'd27: rom_255 = 8'd201;
         7'd28: rom_255 = 8'd197;
         7'd29: rom_255 = 8'd193;
         7'd30: rom_255 = 8'd189;
         7'd31: rom_255 = 8'd185;
         7'd32: rom_255 = 8'd180;
         7'd33: rom_255 = 8'd176;
         7'd34: rom_255 = 8'd171;
         7'd35: rom_255 = 8'd167;
         7'd36: rom_255 = 8'd162;
         7'd37: rom_255 = 8'd157;
         7'd38: rom_255 = 8'd152;
         7'd39: rom_255 = 8'd147;
         7'd40: rom_255 = 8'd142;
         7'd41: rom_255 = 8'd136;
         7'd42: rom_255 = 8'd131;
         7'd43: rom_255 = 8'd126;
         7'd44: rom_255 = 8'd120;
         7'd45: rom_255 = 8'd115;
         7'd46: rom_255 = 8'd109;
         7'd47: rom_255 = 8'd103;
         7'd48: rom_255 = 8'd98;
         7'd49: rom_255 = 8'd92;
         7'd50: rom_255 = 8'd86;
         7'd51: rom_255 = 8'd80;
         7'd52: rom_255 = 8'd74;
         7'd53: rom_255 = 8'd68;
         7'd54: rom_255 = 8'd62;
         7'd55: rom_255 = 8'd56;
         7'd56: rom_255 = 8'd50;
         7'd57: rom_255 = 8'd44;
         7'd58: rom_255 = 8'd37;
         7'd59: rom_255 = 8'd31;
         7'd60: rom_255 = 8'd25;
         7'd61: rom_255 = 8'd19;
         7'd62: rom_255 = 8'd13;
         7'd63: rom_255 = 8'd6;
         default: rom_255 = 8'd0;
      endcase
   endfunction

   function automatic logic [6:0] rom_127(input logic [6:0] a);
      case (a)
         7'd0:  rom_127 = 7'd127;
         7'd1:  rom_127 = 7'd127;
         7'd2:  rom_127 = 7'd127;
         7'd3:  rom_127 = 7'd127;
         7'd4:  rom_127 = 7'd126;
         7'd5:  rom_127 = 7'd126;
         7'd6:  rom_127 = 7'd126;
         7'd7:  rom_127 = 7'd125;
         7'd8:  rom_127 = 7'd125;
         7'd9:  rom_127 = 7'd124;
         7'd10: rom_127 = 7'd123;
         7'd11: rom_127 = 7'd122;
         7'd12: rom_127 = 7'd122;
         7'd13: rom_127 = 7'd121;
         7'd14: rom_127 = 7'd120;
         7'd15: rom_127 = 7'd118;
         7'd16: rom_127 = 7'd117;
         7'd17: rom_127 = 7'd116;
         7'd18: rom_127 = 7'd115;
         7'd19: rom_127 = 7'd113;
         7'd20: rom_127 = 7'd112;
         7'd21: rom_127 = 7'd111;
         7'd22: rom_127 = 7'd109;
         7'd23: rom_127 = 7'd107;
         7'd24: rom_127 = 7'd106;
         7'd25: rom_127 = 7'd104;
         7'd26: rom_127 = 7'd102;
         7'd27: rom_127 = 7'd100;
         7'd28: rom_127 = 7'd98;
         7'd29: rom_127 = 7'd96;
         7'd30: rom_127 = 7'd94;
         7'd31: rom_127 = 7'd92;
         7'd32: rom_127 = 7'd90;
         7'd33: rom_127 = 7'd88;
         7'd34: rom_127 = 7'd85;
         7'd35: rom_127 = 7'd83;
         7'd36: rom_127 = 7'd81;
         7'd37: rom_127 = 7'd78;
         7'd38: rom_127 = 7'd76;
         7'd39: rom_127 = 7'd73;
         7'd40: rom_127 = 7'd71;
         7'd41: rom_127 = 7'd68;
         7'd42: rom_127 = 7'd65;
         7'd43: rom_127 = 7'd63;
         7'd44: rom_127 = 7'd60;
         7'd45: rom_127 = 7'd57;
         7'd46: rom_127 = 7'd54;
         7'd47: rom_127 = 7'd51;
         7'd48: rom_127 = 7'd49;
         7'd49: rom_127 = 7'd46;
         7'd50: rom_127 = 7'd43;
         7'd51: rom_127 = 7'd40;
         7'd52: rom_127 = 7'd37;
         7'd53: rom_127 = 7'd34;
         7'd54: rom_127 = 7'd31;
         7'd55: rom_127 = 7'd28;
         7'd56: rom_127 = 7'd25;
         7'd57: rom_127 = 7'd22;
         7'd58: rom_127 = 7'd19;
         7'd59: rom_127 = 7'd16;
         7'd60: rom_127 = 7'd12;
         7'd61: rom_127 = 7'd9;
         7'd62: rom_127 = 7'd6;
         7'd63: rom_127 = 7'd3;
         default: rom_127 = 7'd0;
      endcase
   endfunction

   // Outputs come from the phase held before the edge, so they lag the accumulator by one cycle.
   always_comb begin
      ph_100k_d  = ph_100k_q + FTW_100K;
      ph_1M_d    = ph_1M_q + FTW_1M;
      mag_100k   = rom_255(fold_addr(ph_100k_q[31:24]));
      mag_1M     = rom_127(fold_addr(ph_1M_q[31:24]));
      cos_100k_d = {1'b0, mag_100k};
      cos_1M_d   = {1'b0, mag_1M};
      if (fold_neg(ph_100k_q[31:24])) begin
         cos_100k_d = -cos_100k_d;
      end
      if (fold_neg(ph_1M_q[31:24])) begin
         cos_1M_d = -cos_1M_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph_100k_q  <= '0;
         ph_1M_q    <= '0;
         cos_100k_q <= '0;
         cos_1M_q   <= '0;
      end else begin
         ph_100k_q  <= ph_100k_d;
         ph_1M_q    <= ph_1M_d;
         cos_100k_q <= cos_100k_d;
         cos_1M_q   <= cos_1M_d;
      end
   end

   assign dds_o.cos_100k = cos_100k_q;
   assign dds_o.cos_1M   = cos_1M_q;

endmodule

// File: tb/tb_cos_make_dds.sv
// Bench for cos_make_dds: real-valued cosine model compared every cycle, plus literal anchor points.
module tb_cos_make_dds;

   localparam logic [31:0] FTW_100K = 32'd4294967;
   localparam logic [31:0] FTW_1M   = 32'd42949673;
   localparam real PI = 3.14159265358979323846;

   localparam int PIN1M_N   [5] = '{1, 26, 51, 76, 101};
   localparam int PIN1M_V   [5] = '{127, 0, -127, 0, 127};
   localparam int PIN100K_N [4] = '{1, 251, 501, 1001};
   localparam int PIN100K_V [4] = '{255, 6, -255, 255};

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   n = -1;

   cos_make_dds_if dds ();

   cos_make_dds #(
      .FTW_100K (FTW_100K),
      .FTW_1M   (FTW_1M)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dds_o (dds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
      end
   endtask

   function automatic int ref_cos(input int amp, input int p);
      real v;
      v = amp * $cos(2.0 * PI * p / 256.0);
      if (v >= 0.0) return int'($floor(v + 0.5));
      else          return -int'($floor(-v + 0.5));
   endfunction

   function automatic int ref_index(input int k, input logic [31:0] ftw);
      longint unsigned ph;
      ph = (longint'(k) * longint'(ftw)) % 64'h1_0000_0000;
      return int'(ph >> 24);
   endfunction

   // n counts rising edges since the last edge that saw reset low.
   always @(posedge clk) begin
      if (!rst_n)       n = 0;
      else if (n >= 0)  n = n + 1;
   end

   always @(negedge clk) begin
      if (n == 0) begin
         chk("rst_cos100k", longint'(dds.cos_100k), 0);
         chk("rst_cos1M",   longint'(dds.cos_1M), 0);
         chk("rst_ph100k",  longint'(dut.ph_100k_q), 0);
         chk("rst_ph1M",    longint'(dut.ph_1M_q), 0);
      end else if (n > 0) begin
         chk("gold_cos100k", longint'(dds.cos_100k), ref_cos(255, ref_index(n - 1, FTW_100K)));
         chk("gold_cos1M",   longint'(dds.cos_1M),   ref_cos(127, ref_index(n - 1, FTW_1M)));
         if (n == 1) begin
            chk("first_ph100k", longint'(dut.ph_100k_q), longint'(FTW_100K));
            chk("first_ph1M",   longint'(dut.ph_1M_q),   longint'(FTW_1M));
         end
         for (int k = 0; k < 5; k++)
            if (n == PIN1M_N[k]) chk("pin_cos1M", longint'(dds.cos_1M), PIN1M_V[k]);
         for (int k = 0; k < 4; k++)
            if (n == PIN100K_N[k]) chk("pin_cos100k", longint'(dds.cos_100k), PIN100K_V[k]);
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b1;
      repeat (333) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (65536 + 16) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
